mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the pipelined MIPS core, directly downstream of the `execution` ALU. It consumes the ALU result (`d1_out`) as either a load/store effective address or a pass-through result. It runs byte/half/word loads and stores against a data memory using a req/ack handshake with arbitrary wait states. It stalls the EX stage while an access is outstanding and presents one registered result per instruction to writeback.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register index).
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `ex_valid` in 1 — EX presents a valid instruction this cycle.
- `ex_alu_result` in 32 — ALU output; effective address for memory ops.
- `ex_store_data` in 32 — rt value for stores.
- `ex_mem_read` / `ex_mem_write` in 1 — load / store; write wins if both set.
- `ex_size` in 2 — 00 byte, 01 half, 10 word, 11 treated as word.
- `ex_load_unsigned` in 1 — zero-extend loads (LBU/LHU).
- `ex_rd` in 5, `ex_reg_write` in 1 — destination register and write enable.
- `ms_stall` out 1 — EX must hold its outputs.
- `dmem_req` out 1, `dmem_we` out 1 — memory request and write enable.
- `dmem_addr` out 32 — word-aligned address (`[1:0]` = 0).
- `dmem_wdata` out 32 — store data.
- `dmem_be` out 4 — byte-lane enables.
- `dmem_rdata` in 32, `dmem_ack` in 1 — read data and completion.
- `wb_valid` out 1, `wb_data` out 32, `wb_rd` out 5, `wb_reg_write` out 1 — registered writeback bundle.
- `misalign` out 1 — one-cycle pulse when an access is misaligned.

## Operation
- FSM states: IDLE and ACCESS. Reset puts the FSM in IDLE and clears every output to 0.
- IDLE with `ex_valid` and no memory op: on the next edge `wb_valid` = 1, `wb_data` = `ex_alu_result`, and `wb_rd`/`wb_reg_write` are copied. No stall.
- IDLE with an aligned memory op:
  - Latch the access, go to ACCESS, and register `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`.
  - `ms_stall` = 1 combinationally in this cycle.
- ACCESS:
  - Request outputs are held stable until `dmem_ack`. `ms_stall` = !`dmem_ack`.
  - On the `dmem_ack` edge: drop `dmem_req`, return to IDLE, and pulse `wb_valid`.
  - Loads: `wb_data` = formatted `dmem_rdata`, `wb_reg_write` as latched.
  - Stores: `wb_reg_write` = 0.
  - EX input is ignored while in ACCESS.
- Misaligned access: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - No memory request is made and the FSM stays in IDLE.
  - Next edge: `misalign` = 1, `wb_valid` = 1, `wb_reg_write` = 0.
- Byte lanes are little-endian.
  - `dmem_be`: byte = 0001 << `a[1:0]`; half = 0011 << (2·`a[1]`); word = 1111.
  - Store data is replicated: the byte ×4, the half ×2.
- Load formatting: select the lane by `a[1:0]` (byte) or `a[1]` (half), then sign-extend, or zero-extend when `ex_load_unsigned` = 1.
- `wb_valid` = 0 in every cycle with no completion. `wb_data`/`wb_rd` hold their last value.

## Timing
- Non-memory op: 1 cycle, with no stall.
- Memory op with zero wait states (ack in the first ACCESS cycle): accept edge plus ack edge, so `wb_valid` asserts 2 edges after the op is presented and EX is stalled for 1 cycle.
- Each wait cycle adds 1 cycle of latency and stall.
- `dmem_ack` is ignored in IDLE.
- Reset asserted mid-ACCESS: `dmem_req` deasserts asynchronously and the FSM goes to IDLE. Data memory must tolerate an abandoned request.
- `ms_stall` is combinational from the state, `ex_*` and `dmem_ack`. There is no combinational path from `dmem_rdata` to any output.

## Structure
- `mips_pkg` holds:
  - the size encodings (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10);
  - the FSM state enum;
  - the shared writeback bundle widths.
- Sub-module `mem_align` is purely combinational and holds all byte-lane logic:
  - store side: address plus size produce `be`, replicated `wdata` and the misalign flag;
  - load side: `rdata`, address, size and unsigned produce the formatted word.

## Test plan
- ALU op, `ex_alu_result` = 0x0000_1234, rd = 5 → next edge: `wb_valid` = 1, `wb_data` = 0x1234, `wb_rd` = 5, `ms_stall` never 1.
- LW at 0x100, memory acks after 3 wait cycles with 0xDEAD_BEEF → `dmem_addr`/`be` stable at 0x100/1111 throughout; `ms_stall` high 4 cycles; `wb_data` = 0xDEAD_BEEF.
- LB at 0x103 with `rdata` 0x80_00_00_00 → `wb_data` = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x102 with data 0x0000_ABCD → `dmem_be` = 1100, `wdata` = 0xABCD_ABCD, `we` = 1, `wb_reg_write` = 0.
- LW at 0x101 → no `dmem_req`; next edge `misalign` = 1, `wb_valid` = 1, `wb_reg_write` = 0.
- Deassert `rst_n` during ACCESS → `dmem_req`, `ms_stall` and `wb_valid` go 0 immediately. After release, an ALU op completes in 1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-access stage: access size encodings,
// FSM state type and writeback bundle widths.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } ms_state_e;

endpackage

// File: rtl/mem_align.sv
// Little-endian byte-lane logic: store-side enables/replication/misalign
// detection and load-side lane selection with sign or zero extension.
module mem_align
    import mips_pkg::*;
(
    input  logic [1:0]        st_off,
    input  logic [1:0]        st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic [BE_W-1:0]   st_be,
    output logic [DATA_W-1:0] st_wdata,
    output logic              st_misalign,
    input  logic [DATA_W-1:0] ld_rdata,
    input  logic [1:0]        ld_off,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size 2'b11 falls through to the word defaults on both sides.
    always_comb begin
        st_be       = 4'b1111;
        st_wdata    = st_data;
        st_misalign = (st_off != 2'b00);
        case (st_size)
            SZ_BYTE: begin
                st_be       = 4'b0001 << st_off;
                st_wdata    = {4{st_data[7:0]}};
                st_misalign = 1'b0;
            end
            SZ_HALF: begin
                st_be       = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata    = {2{st_data[15:0]}};
                st_misalign = st_off[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS memory-access stage: pass-through of ALU results, byte/half/word
// loads and stores over a req/ack data-memory port, one registered WB result.
module mem_access
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_load_unsigned,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    output logic              ms_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic              misalign
);

    ms_state_e         state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [1:0]        off_q, off_d, size_q, size_d;
    logic              uns_q, uns_d, acc_rw_q, acc_rw_d;
    logic [REG_W-1:0]  acc_rd_q, acc_rd_d;
    logic              wbv_q, wbv_d, wbrw_q, wbrw_d, mis_q, mis_d;
    logic [DATA_W-1:0] wbd_q, wbd_d;
    logic [REG_W-1:0]  wbrd_q, wbrd_d;

    logic              mem_op, stall_c;
    logic              st_mis;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_wdata, ld_data;

    assign mem_op = ex_mem_read | ex_mem_write;

    mem_align u_align (
        .st_off      (ex_alu_result[1:0]),
        .st_size     (ex_size),
        .st_data     (ex_store_data),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .st_misalign (st_mis),
        .ld_rdata    (dmem_rdata),
        .ld_off      (off_q),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        acc_rd_d = acc_rd_q;
        acc_rw_d = acc_rw_q;
        wbv_d    = 1'b0;
        wbd_d    = wbd_q;
        wbrd_d   = wbrd_q;
        wbrw_d   = wbrw_q;
        mis_d    = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!mem_op || st_mis) begin
                        wbv_d  = 1'b1;
                        wbd_d  = ex_alu_result;
                        wbrd_d = ex_rd;
                        wbrw_d = ex_reg_write & !mem_op;
                        mis_d  = mem_op;
                    end else begin
                        state_d  = ST_ACCESS;
                        req_d    = 1'b1;
                        we_d     = ex_mem_write;
                        addr_d   = {ex_alu_result[DATA_W-1:2], 2'b00};
                        wdata_d  = st_wdata;
                        be_d     = st_be;
                        off_d    = ex_alu_result[1:0];
                        size_d   = ex_size;
                        uns_d    = ex_load_unsigned;
                        acc_rd_d = ex_rd;
                        acc_rw_d = ex_reg_write;
                        stall_c  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                stall_c = !dmem_ack;
                if (dmem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    wbrd_d  = acc_rd_q;
                    wbrw_d  = acc_rw_q & !we_q;
                    if (!we_q) begin
                        wbd_d = ld_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            acc_rd_q <= '0;
            acc_rw_q <= 1'b0;
            wbv_q    <= 1'b0;
            wbd_q    <= '0;
            wbrd_q   <= '0;
            wbrw_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            acc_rd_q <= acc_rd_d;
            acc_rw_q <= acc_rw_d;
            wbv_q    <= wbv_d;
            wbd_q    <= wbd_d;
            wbrd_q   <= wbrd_d;
            wbrw_q   <= wbrw_d;
            mis_q    <= mis_d;
        end
    end

    // Stall is forced low while reset is held, even if EX still offers a memory op.
    assign ms_stall     = rst_n & stall_c;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_valid     = wbv_q;
    assign wb_data      = wbd_q;
    assign wb_rd        = wbrd_q;
    assign wb_reg_write = wbrw_q;
    assign misalign     = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a byte-addressed
// memory model; the bench plays the data memory and drives dmem_ack itself.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_load_unsigned, ex_reg_write;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rd;
    logic        ms_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, misalign;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  mem [0:1023];

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_size(ex_size), .ex_load_unsigned(ex_load_unsigned), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ms_stall(ms_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_load_unsigned = 1'b0; ex_reg_write = 1'b0; ex_size = 2'b00;
        ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    endtask

    // Random EX traffic while an access is outstanding; the stage must ignore it.
    task automatic junk_inputs();
        ex_valid = 1'b1; ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
        ex_size = 2'($urandom); ex_load_unsigned = 1'($urandom); ex_reg_write = 1'($urandom);
        ex_alu_result = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);
    endtask

    task automatic do_op(input logic mr, input logic mw, input logic [1:0] sz, input logic uns,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input int unsigned waits);
        int unsigned n, a, base, stalls;
        logic        memop, mis, is_store;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld, word;
        memop    = mr | mw;
        is_store = mw;
        n        = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a        = int'(alu[9:0]);
        mis      = memop && ((a % n) != 0);
        base     = a - (a % 4);
        exp_be   = '0;
        exp_wd   = '0;
        exp_ld   = '0;
        for (int unsigned i = 0; i < n; i++) exp_be[(a % 4) + i] = 1'b1;
        for (int unsigned k = 0; k < 4; k++) exp_wd[8*k +: 8] = sd[8*(k % n) +: 8];
        for (int unsigned i = 0; i < n; i++) exp_ld[8*i +: 8] = mem[(a + i) % 1024];
        if (!uns && n < 4 && exp_ld[8*n-1]) exp_ld = exp_ld | (32'hFFFF_FFFF << (8*n));
        word = {mem[(base+3)%1024], mem[(base+2)%1024], mem[(base+1)%1024], mem[base%1024]};

        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = mr; ex_mem_write = mw; ex_size = sz;
        ex_load_unsigned = uns; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw;
        stalls = 0;
        @(negedge clk);
        chk("stall_accept", {31'd0, ms_stall}, {31'd0, memop && !mis});
        if (ms_stall) stalls++;
        @(posedge clk); #1;
        if (!memop || mis) begin
            idle_inputs();
            chk("wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("misalign", {31'd0, misalign}, {31'd0, mis});
            chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, rw && !memop});
            chk("no_req", {31'd0, dmem_req}, 32'd0);
            if (!mis) begin
                chk("wb_data_alu", wb_data, alu);
                chk("wb_rd_alu", {27'd0, wb_rd}, {27'd0, rd});
            end
        end else begin
            junk_inputs();
            chk("req", {31'd0, dmem_req}, 32'd1);
            chk("we", {31'd0, dmem_we}, {31'd0, is_store});
            chk("addr", dmem_addr, {alu[31:2], 2'b00});
            chk("be", {28'd0, dmem_be}, {28'd0, exp_be});
            if (is_store) chk("wdata", dmem_wdata, exp_wd);
            for (int unsigned w = 0; w < waits; w++) begin
                dmem_ack = 1'b0; dmem_rdata = $urandom;
                @(negedge clk);
                if (ms_stall) stalls++;
                chk("addr_hold", dmem_addr, {alu[31:2], 2'b00});
                chk("be_hold", {28'd0, dmem_be}, {28'd0, exp_be});
                chk("req_hold", {31'd0, dmem_req}, 32'd1);
                @(posedge clk); #1;
                junk_inputs();
            end
            dmem_ack = 1'b1; dmem_rdata = word;
            @(negedge clk);
            if (ms_stall) stalls++;
            chk("stall_count", stalls, waits + 1);
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            idle_inputs();
            chk("wb_valid_mem", {31'd0, wb_valid}, 32'd1);
            chk("req_drop", {31'd0, dmem_req}, 32'd0);
            chk("wb_rd_mem", {27'd0, wb_rd}, {27'd0, rd});
            chk("wb_rw_mem", {31'd0, wb_reg_write}, {31'd0, rw && !is_store});
            if (!is_store) chk("wb_data_load", wb_data, exp_ld);
            else for (int unsigned i = 0; i < n; i++) mem[(a + i) % 1024] = sd[8*i +: 8];
        end
        @(posedge clk); #1;
        chk("wb_valid_pulse", {31'd0, wb_valid}, 32'd0);
        chk("misalign_pulse", {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int unsigned kind, n, a;
        logic [1:0]  sz;
        idle_inputs();
        dmem_ack = 1'b0; dmem_rdata = '0;
        for (int unsigned i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_stall", {31'd0, ms_stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0);
        {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} = 32'hDEAD_BEEF;
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 3);
        {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} = 32'h8000_0000;
        do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 0);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd9, 1'b1, 1);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 5'd3, 1'b1, 2);
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd4, 1'b1, 0);

        // reset while an access is outstanding
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_size = 2'b10; ex_alu_result = 32'h200;
        ex_rd = 5'd1; ex_reg_write = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, dmem_req}, 32'd0);
        chk("async_stall", {31'd0, ms_stall}, 32'd0);
        chk("async_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'hCAFE_0001, 32'h0, 5'd31, 1'b1, 0);

        for (int it = 0; it < 200; it++) begin
            kind = $urandom_range(0, 2);
            sz = 2'($urandom);
            n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) a = a - (a % n);
            r = $urandom;
            r[9:0] = 10'(a);
            if (kind == 0)
                do_op(1'b0, 1'b0, sz, 1'($urandom), r, $urandom, 5'($urandom), 1'($urandom), 0);
            else if (kind == 1)
                do_op(1'b1, 1'b0, sz, 1'($urandom), r, $urandom, 5'($urandom), 1'($urandom),
                      $urandom_range(0, 4));
            else
                do_op(1'($urandom), 1'b1, sz, 1'($urandom), r, $urandom, 5'($urandom),
                      1'($urandom), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
